operand_scoreboard: RTL and testbench

Decode-stage operand resolution unit with latency-aware hazard tracking. It generalises the single-cycle operand mux to NUM_RD read ports and NUM_FWD forwarding buses. A per-register countdown scoreboard detects producers whose results are not yet on any forwarding bus, such as load-use or multi-cycle multiply, and raises a stall request. It sits between the decoder, regfile read ports and the ID/EX pipeline register.

---
 rtl/operand_scoreboard_pkg.sv | 16 +
 rtl/operand_fwd_mux.sv | 41 ++++
 rtl/operand_scoreboard.sv | 108 ++++++++++
 tb/tb_operand_scoreboard.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_scoreboard_pkg.sv
// Shared widths, constants and latency classes for the operand scoreboard.
package operand_scoreboard_pkg;

  // Default datapath and register-address widths.
  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NopRegAddr = '0;

  // Cycles from issue until a result reaches a forwarding bus.
  localparam int unsigned LatAlu  = 0;
  localparam int unsigned LatLoad = 1;
  localparam int unsigned LatMul  = 3;

endpackage

// File: rtl/operand_fwd_mux.sv
// Single-port operand resolution: reset, immediate, r0, forwarding buses, regfile.
module operand_fwd_mux
  import operand_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W     = RegBus,
  parameter int unsigned REG_ADDR_W = RegAddrBus,
  parameter int unsigned NUM_FWD    = 2
) (
  input  logic                          rst_i,
  input  logic                          rd_en_i,
  input  logic [REG_ADDR_W-1:0]         rd_addr_i,
  input  logic [DATA_W-1:0]             rf_data_i,
  input  logic [DATA_W-1:0]             imm_i,
  input  logic [NUM_FWD-1:0]            fwd_wreg_i,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0]     fwd_wdata_i,
  output logic [DATA_W-1:0]             operand_o
);

  logic hit;

  // Lowest-index matching bus wins; reset, immediate and r0 override everything.
  always_comb begin
    operand_o = rf_data_i;
    hit       = 1'b0;
    for (int f = 0; f < int'(NUM_FWD); f++) begin
      if (!hit && fwd_wreg_i[f] && (fwd_wd_i[f*REG_ADDR_W +: REG_ADDR_W] == rd_addr_i)) begin
        operand_o = fwd_wdata_i[f*DATA_W +: DATA_W];
        hit       = 1'b1;
      end
    end
    if (rst_i) begin
      operand_o = DATA_W'(ZeroWord);
    end else if (!rd_en_i) begin
      operand_o = imm_i;
    end else if (rd_addr_i == REG_ADDR_W'(NopRegAddr)) begin
      operand_o = DATA_W'(ZeroWord);
    end
  end

endmodule

// File: rtl/operand_scoreboard.sv
// Decode-stage operand resolution with a per-register latency scoreboard.
// Optional: define OPERAND_SCOREBOARD_STALL_CNT_EN to add a saturating stall-cycle counter.
module operand_scoreboard
  import operand_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W     = RegBus,
  parameter int unsigned REG_ADDR_W = RegAddrBus,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_FWD    = 2,
  parameter int unsigned LAT_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD-1:0]             rd_en_i,
  input  logic [NUM_RD*REG_ADDR_W-1:0]  rd_addr_i,
  input  logic [NUM_RD*DATA_W-1:0]      rf_data_i,
  input  logic [DATA_W-1:0]             imm_i,
  input  logic [NUM_FWD-1:0]            fwd_wreg_i,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0]     fwd_wdata_i,
  input  logic                          issue_valid_i,
  input  logic                          issue_wreg_i,
  input  logic [REG_ADDR_W-1:0]         issue_wd_i,
  input  logic [LAT_W-1:0]              issue_lat_i,
  output logic [NUM_RD*DATA_W-1:0]      operand_o,
`ifdef OPERAND_SCOREBOARD_STALL_CNT_EN
  output logic [31:0]                   stall_cycles_o,
`endif
  output logic                          stall_req_o,
  output logic                          issue_ack_o
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

  logic [LAT_W-1:0]  cnt_q [NumRegs];
  logic [LAT_W-1:0]  cnt_d [NumRegs];
  logic [NUM_RD-1:0] blocked;

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_port
    operand_fwd_mux #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_FWD    (NUM_FWD)
    ) u_fwd_mux (
      .rst_i       (rst),
      .rd_en_i     (rd_en_i[p]),
      .rd_addr_i   (rd_addr_i[p*REG_ADDR_W +: REG_ADDR_W]),
      .rf_data_i   (rf_data_i[p*DATA_W +: DATA_W]),
      .imm_i       (imm_i),
      .fwd_wreg_i  (fwd_wreg_i),
      .fwd_wd_i    (fwd_wd_i),
      .fwd_wdata_i (fwd_wdata_i),
      .operand_o   (operand_o[p*DATA_W +: DATA_W])
    );
  end

  // A port is blocked when it reads a nonzero register whose producer is still in flight.
  // Only cnt_q feeds this, so issue_* has no combinational path to the stall.
  always_comb begin
    blocked = '0;
    for (int p = 0; p < int'(NUM_RD); p++) begin
      blocked[p] = rd_en_i[p]
                && (rd_addr_i[p*REG_ADDR_W +: REG_ADDR_W] != REG_ADDR_W'(NopRegAddr))
                && (cnt_q[rd_addr_i[p*REG_ADDR_W +: REG_ADDR_W]] != '0);
    end
    stall_req_o = !rst && (|blocked);
    issue_ack_o = issue_valid_i && !stall_req_o;
  end

  // Decrement every pending counter; an accepted writer reloads its destination (youngest wins).
  always_comb begin
    for (int r = 0; r < int'(NumRegs); r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : cnt_q[r];
    end
    if (issue_ack_o && issue_wreg_i && (issue_wd_i != REG_ADDR_W'(NopRegAddr))) begin
      cnt_d[issue_wd_i] = issue_lat_i;
    end
  end

  // Scoreboard state; reset clears all pending producers at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(NumRegs); r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NumRegs); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

`ifdef OPERAND_SCOREBOARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_req_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_scoreboard.sv
// Directed self-checking bench for operand_scoreboard.
// Also exercises OPERAND_SCOREBOARD_STALL_CNT_EN when that macro is defined.
module tb_operand_scoreboard;
  import operand_scoreboard_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NF = 2;
  localparam int unsigned LW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rf_data;
  logic [DW-1:0]     imm;
  logic [NF-1:0]     fwd_wreg;
  logic [NF*AW-1:0]  fwd_wd;
  logic [NF*DW-1:0]  fwd_wdata;
  logic              issue_valid;
  logic              issue_wreg;
  logic [AW-1:0]     issue_wd;
  logic [LW-1:0]     issue_lat;
  logic [NR*DW-1:0]  operand;
  logic              stall_req;
  logic              issue_ack;
`ifdef OPERAND_SCOREBOARD_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int n_stall;

  always #5 clk = ~clk;

  operand_scoreboard #(
    .DATA_W     (DW),
    .REG_ADDR_W (AW),
    .NUM_RD     (NR),
    .NUM_FWD    (NF),
    .LAT_W      (LW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_en_i        (rd_en),
    .rd_addr_i      (rd_addr),
    .rf_data_i      (rf_data),
    .imm_i          (imm),
    .fwd_wreg_i     (fwd_wreg),
    .fwd_wd_i       (fwd_wd),
    .fwd_wdata_i    (fwd_wdata),
    .issue_valid_i  (issue_valid),
    .issue_wreg_i   (issue_wreg),
    .issue_wd_i     (issue_wd),
    .issue_lat_i    (issue_lat),
    .operand_o      (operand),
`ifdef OPERAND_SCOREBOARD_STALL_CNT_EN
    .stall_cycles_o (stall_cycles),
`endif
    .stall_req_o    (stall_req),
    .issue_ack_o    (issue_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rd_en       = '0;
    rd_addr     = '0;
    rf_data     = '0;
    imm         = 32'hCAFE_0001;
    fwd_wreg    = '0;
    fwd_wd      = '0;
    fwd_wdata   = '0;
    issue_valid = 1'b0;
    issue_wreg  = 1'b0;
    issue_wd    = '0;
    issue_lat   = '0;
  endtask

  task automatic rd_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_en[p]             = 1'b1;
    rd_addr[p*AW +: AW]  = a;
    rf_data[p*DW +: DW]  = d;
  endtask

  task automatic fwd_bus(input int f, input logic [AW-1:0] a, input logic [DW-1:0] d);
    fwd_wreg[f]           = 1'b1;
    fwd_wd[f*AW +: AW]    = a;
    fwd_wdata[f*DW +: DW] = d;
  endtask

  task automatic issue(input logic [AW-1:0] wd, input int unsigned lat);
    issue_valid = 1'b1;
    issue_wreg  = 1'b1;
    issue_wd    = wd;
    issue_lat   = LW'(lat);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts stalled cycles of the current read until release; bounded at 10.
  task automatic count_stall(output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!stall_req) break;
      n++;
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    rd_port(0, 5'd3, 32'h1111);
    rd_port(1, 5'd4, 32'h2222);
    #3;
    check("rst_op0", operand[0 +: DW], 32'h0);
    check("rst_op1", operand[DW +: DW], 32'h0);
    check("rst_stall", {31'b0, stall_req}, 32'h0);
    tick();
    rst = 1'b0;
    idle();

    // ALU chain
    issue(5'd3, LatAlu);
    @(negedge clk);
    check("alu_ack", {31'b0, issue_ack}, 32'h1);
    check("alu_imm", operand[0 +: DW], 32'hCAFE_0001);
    tick();
    idle();
    rd_port(0, 5'd3, 32'h9999);
    fwd_bus(0, 5'd3, 32'h1234);
    @(negedge clk);
    check("alu_stall", {31'b0, stall_req}, 32'h0);
    check("alu_op", operand[0 +: DW], 32'h1234);
    tick();

    // Load-use
    idle();
    issue(5'd4, LatLoad);
    @(negedge clk);
    check("ld_ack0", {31'b0, issue_ack}, 32'h1);
    tick();
    idle();
    rd_port(0, 5'd4, 32'h0);
    issue(5'd9, LatAlu);
    @(negedge clk);
    check("ld_stall", {31'b0, stall_req}, 32'h1);
    check("ld_nack", {31'b0, issue_ack}, 32'h0);
    tick();
    fwd_bus(1, 5'd4, 32'hBEEF);
    @(negedge clk);
    check("ld_release", {31'b0, stall_req}, 32'h0);
    check("ld_op", operand[0 +: DW], 32'hBEEF);
    check("ld_ack1", {31'b0, issue_ack}, 32'h1);
    tick();

    // Multi-cycle producer
    idle();
    issue(5'd7, LatMul);
    tick();
    idle();
    rd_port(1, 5'd7, 32'h77);
    issue(5'd11, LatAlu);
    count_stall(n_stall);
    check("mul_stall_len", n_stall, 32'd3);
    check("mul_op", operand[DW +: DW], 32'h77);
    check("mul_ack", {31'b0, issue_ack}, 32'h1);
`ifdef OPERAND_SCOREBOARD_STALL_CNT_EN
    check("stall_cnt", stall_cycles, 32'd4);
`endif
    tick();
    idle();
    issue(5'd7, LatMul);
    tick();
    idle();
    rd_port(1, 5'd8, 32'h55);
    issue_valid = 1'b1;
    @(negedge clk);
    check("r8_stall", {31'b0, stall_req}, 32'h0);
    check("r8_op", operand[DW +: DW], 32'h55);
    check("r8_ack", {31'b0, issue_ack}, 32'h1);
    tick();

    // Zero register and forwarding priority
    idle();
    issue(5'd0, 5);
    @(negedge clk);
    check("r0_ack", {31'b0, issue_ack}, 32'h1);
    tick();
    idle();
    rd_port(0, 5'd0, 32'hDEAD);
    rd_port(1, 5'd2, 32'hFFFF);
    fwd_bus(0, 5'd2, 32'hA);
    fwd_bus(1, 5'd2, 32'hB);
    @(negedge clk);
    check("r0_stall", {31'b0, stall_req}, 32'h0);
    check("r0_op", operand[0 +: DW], 32'h0);
    check("prio_op", operand[DW +: DW], 32'hA);
    fwd_wreg = 2'b10;
    #1;
    check("fwd1_op", operand[DW +: DW], 32'hB);
    fwd_wreg = 2'b00;
    #1;
    check("rf_op", operand[DW +: DW], 32'hFFFF);
    tick();

    // WAW: the younger, shorter writer determines the stall
    idle();
    issue(5'd5, 4);
    tick();
    issue(5'd5, 1);
    tick();
    idle();
    rd_port(0, 5'd5, 32'h5);
    count_stall(n_stall);
    check("waw_stall_len", n_stall, 32'd1);
    tick();

    // Asynchronous reset while stalled
    idle();
    issue(5'd6, 3);
    tick();
    idle();
    rd_port(0, 5'd6, 32'h66);
    rd_port(1, 5'd6, 32'h66);
    @(negedge clk);
    check("rst_pre_stall", {31'b0, stall_req}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_stall", {31'b0, stall_req}, 32'h0);
    check("rst_mid_op0", operand[0 +: DW], 32'h0);
    check("rst_mid_op1", operand[DW +: DW], 32'h0);
`ifdef OPERAND_SCOREBOARD_STALL_CNT_EN
    check("rst_stall_cnt", stall_cycles, 32'd0);
`endif
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_stall", {31'b0, stall_req}, 32'h0);
    check("post_rst_op0", operand[0 +: DW], 32'h66);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
